// File: rtl/usb_frame_pkg.sv
// rtl/usb_frame_pkg.sv - shared symbols, state encoding and error codes for the USB frame parser
package usb_frame_pkg;

    localparam int HEADER_SYMBOL  = 85;
    localparam int HEADER_COUNT   = 12;
    localparam int TRAILER_SYMBOL = 170;
    localparam int TRAILER_COUNT  = 8;
    localparam logic [7:0] ERROR_SYMBOL = 8'hEE;

    typedef enum logic [2:0] {
        HUNT,
        LEN_LO,
        LEN_HI,
        DATA_LO,
        DATA_HI,
        TRAILER
    } frame_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_TRAILER = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/usb_gap_timer.sv
// rtl/usb_gap_timer.sv - clearable idle counter pulsing once after GAP_TIMEOUT enabled clocks
module usb_gap_timer #(
    parameter int GAP_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam int CW = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TERM = CW'(GAP_TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // A clear in the terminal cycle suppresses the pulse.
    always_comb begin
        expire_o = en_i && !clr_i && (cnt_q == TERM);
        cnt_d    = cnt_q + CW'(1);
        if (clr_i || !en_i || expire_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/usb_frame_parser.sv
// rtl/usb_frame_parser.sv - header hunt, length/payload extraction and trailer check on a byte stream
module usb_frame_parser
    import usb_frame_pkg::*;
#(
    parameter int BYTE_WIDTH                = 8,
    parameter int WORD_WIDTH                = 16,
    parameter int HEADER_KEY_SYMBOL         = HEADER_SYMBOL,
    parameter int HEADER_KEY_SYMBOL_NUMBER  = HEADER_COUNT,
    parameter int TRAILER_KEY_SYMBOL        = TRAILER_SYMBOL,
    parameter int TRAILER_KEY_SYMBOL_NUMBER = TRAILER_COUNT,
    parameter int MAX_WORDS                 = 256,
    parameter int ADDR_WIDTH                = 8,
    parameter int GAP_TIMEOUT               = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BYTE_WIDTH-1:0] byte_data,
    input  logic                  byte_valid,
    output logic [WORD_WIDTH-1:0] word_data,
    output logic [ADDR_WIDTH-1:0] word_addr,
    output logic                  word_valid,
    output logic                  frame_done,
    output logic                  frame_error,
    output logic [1:0]            err_code
);

    localparam int LEN_W  = 2 * BYTE_WIDTH;
    localparam int IDX_W  = $clog2(MAX_WORDS + 1);
    localparam int HCNT_W = $clog2(HEADER_KEY_SYMBOL_NUMBER + 1);
    localparam int TCNT_W = $clog2(TRAILER_KEY_SYMBOL_NUMBER + 1);

    localparam logic [BYTE_WIDTH-1:0] HDR_SYM  = BYTE_WIDTH'(HEADER_KEY_SYMBOL);
    localparam logic [BYTE_WIDTH-1:0] TRL_SYM  = BYTE_WIDTH'(TRAILER_KEY_SYMBOL);
    localparam logic [HCNT_W-1:0]     HDR_LAST = HCNT_W'(HEADER_KEY_SYMBOL_NUMBER - 1);
    localparam logic [TCNT_W-1:0]     TRL_LAST = TCNT_W'(TRAILER_KEY_SYMBOL_NUMBER - 1);
    localparam logic [LEN_W-1:0]      LEN_MAX  = LEN_W'(MAX_WORDS);

    frame_state_t state_q, state_d;

    logic [HCNT_W-1:0]     hdr_cnt_q, hdr_cnt_d;
    logic [TCNT_W-1:0]     trl_cnt_q, trl_cnt_d;
    logic [BYTE_WIDTH-1:0] len_lo_q, len_lo_d;
    logic [BYTE_WIDTH-1:0] data_lo_q, data_lo_d;
    logic [IDX_W-1:0]      len_q, len_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    logic [WORD_WIDTH-1:0] word_data_q, word_data_d;
    logic [ADDR_WIDTH-1:0] word_addr_q, word_addr_d;
    logic                  word_valid_q, word_valid_d;
    logic                  frame_done_q, frame_done_d;
    logic                  frame_error_q, frame_error_d;
    logic [1:0]            err_code_q, err_code_d;

    logic [LEN_W-1:0] len_full;
    logic [IDX_W-1:0] idx_inc;
    logic             gap_en;
    logic             gap_expire;

    assign len_full = {byte_data, len_lo_q};
    assign idx_inc  = idx_q + IDX_W'(1);

    // A partially matched header also counts as being mid-frame.
    assign gap_en = (state_q != HUNT) || (hdr_cnt_q != '0);

    usb_gap_timer #(
        .GAP_TIMEOUT(GAP_TIMEOUT)
    ) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .en_i    (gap_en),
        .clr_i   (byte_valid),
        .expire_o(gap_expire)
    );

    always_comb begin
        state_d       = state_q;
        hdr_cnt_d     = hdr_cnt_q;
        trl_cnt_d     = trl_cnt_q;
        len_lo_d      = len_lo_q;
        data_lo_d     = data_lo_q;
        len_d         = len_q;
        idx_d         = idx_q;
        word_data_d   = word_data_q;
        word_addr_d   = word_addr_q;
        err_code_d    = err_code_q;
        word_valid_d  = 1'b0;
        frame_done_d  = 1'b0;
        frame_error_d = 1'b0;

        if (byte_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (byte_data == HDR_SYM) begin
                        if (hdr_cnt_q == HDR_LAST) begin
                            hdr_cnt_d = '0;
                            state_d   = LEN_LO;
                        end else begin
                            hdr_cnt_d = hdr_cnt_q + HCNT_W'(1);
                        end
                    end else begin
                        hdr_cnt_d = '0;
                    end
                end
                LEN_LO: begin
                    len_lo_d = byte_data;
                    state_d  = LEN_HI;
                end
                LEN_HI: begin
                    if (len_full > LEN_MAX) begin
                        frame_error_d = 1'b1;
                        err_code_d    = ERR_LEN;
                        state_d       = HUNT;
                    end else if (len_full == '0) begin
                        trl_cnt_d = '0;
                        state_d   = TRAILER;
                    end else begin
                        len_d   = IDX_W'(len_full);
                        idx_d   = '0;
                        state_d = DATA_LO;
                    end
                end
                DATA_LO: begin
                    data_lo_d = byte_data;
                    state_d   = DATA_HI;
                end
                DATA_HI: begin
                    word_valid_d = 1'b1;
                    word_data_d  = WORD_WIDTH'({byte_data, data_lo_q});
                    word_addr_d  = ADDR_WIDTH'(idx_q);
                    idx_d        = idx_inc;
                    if (idx_inc == len_q) begin
                        trl_cnt_d = '0;
                        state_d   = TRAILER;
                    end else begin
                        state_d = DATA_LO;
                    end
                end
                TRAILER: begin
                    if (byte_data == TRL_SYM) begin
                        if (trl_cnt_q == TRL_LAST) begin
                            frame_done_d = 1'b1;
                            trl_cnt_d    = '0;
                            state_d      = HUNT;
                        end else begin
                            trl_cnt_d = trl_cnt_q + TCNT_W'(1);
                        end
                    end else begin
                        // The offending byte is dropped, never seeded into the header count.
                        frame_error_d = 1'b1;
                        err_code_d    = ERR_TRAILER;
                        trl_cnt_d     = '0;
                        hdr_cnt_d     = '0;
                        state_d       = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end else if (gap_expire) begin
            frame_error_d = 1'b1;
            err_code_d    = ERR_TIMEOUT;
            hdr_cnt_d     = '0;
            trl_cnt_d     = '0;
            idx_d         = '0;
            state_d       = HUNT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HUNT;
            hdr_cnt_q     <= '0;
            trl_cnt_q     <= '0;
            len_lo_q      <= '0;
            data_lo_q     <= '0;
            len_q         <= '0;
            idx_q         <= '0;
            word_data_q   <= '0;
            word_addr_q   <= '0;
            word_valid_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
            err_code_q    <= ERR_NONE;
        end else begin
            state_q       <= state_d;
            hdr_cnt_q     <= hdr_cnt_d;
            trl_cnt_q     <= trl_cnt_d;
            len_lo_q      <= len_lo_d;
            data_lo_q     <= data_lo_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            word_data_q   <= word_data_d;
            word_addr_q   <= word_addr_d;
            word_valid_q  <= word_valid_d;
            frame_done_q  <= frame_done_d;
            frame_error_q <= frame_error_d;
            err_code_q    <= err_code_d;
        end
    end

    assign word_data   = word_data_q;
    assign word_addr   = word_addr_q;
    assign word_valid  = word_valid_q;
    assign frame_done  = frame_done_q;
    assign frame_error = frame_error_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_usb_frame_parser.sv
// tb/tb_usb_frame_parser.sv - self-checking bench for usb_frame_parser against a stream-level parse model
module tb_usb_frame_parser;

    localparam int GAP  = 1024;
    localparam int MAXW = 256;
    localparam int ST_BYTE = 0, ST_TO = 1, ST_RST = 2, ST_END = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_valid = 1'b0;
    logic [15:0] word_data;
    logic [7:0]  word_addr;
    logic        word_valid, frame_done, frame_error;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    usb_frame_parser dut (
        .clk        (clk),
        .rst        (rst),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .word_data  (word_data),
        .word_addr  (word_addr),
        .word_valid (word_valid),
        .frame_done (frame_done),
        .frame_error(frame_error),
        .err_code   (err_code)
    );

    int checks = 0;
    int passed = 0;
    int jitter = 0;
    int cur;

    // Observation word: [28] wv [27] fd [26] fe [25:24] err_code [23:8] word_data [7:0] word_addr
    typedef logic [28:0] obs_t;
    bit         s_vld[$];
    logic [7:0] s_dat[$];
    bit         s_rst[$];
    obs_t        obs[$];
    obs_t        expv[$];
    logic [23:0] raw[$];
    bit          e_wv[], e_fd[], e_fe[];
    logic [15:0] e_wd[];
    logic [7:0]  e_wa[];
    logic [1:0]  e_code[];

    task automatic push_cycle(input bit v, input logic [7:0] d, input bit r);
        s_vld.push_back(v);
        s_dat.push_back(d);
        s_rst.push_back(r);
    endtask

    task automatic push_idle(input int n);
        repeat (n) push_cycle(1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic push_rst();
        push_cycle(1'b0, 8'h00, 1'b1);
    endtask

    task automatic clear_stim();
        s_vld.delete();
        s_dat.delete();
        s_rst.delete();
        push_rst();
    endtask

    task automatic push_byte(input logic [7:0] b);
        if (jitter != 0) push_idle($urandom_range(0, 2));
        push_cycle(1'b1, b, 1'b0);
    endtask

    task automatic push_rep(input logic [7:0] b, input int n);
        repeat (n) push_byte(b);
    endtask

    task automatic push_word(input logic [15:0] w);
        push_byte(w[7:0]);
        push_byte(w[15:8]);
    endtask

    task automatic push_frame(input int len);
        push_rep(8'h55, 12);
        push_word(len[15:0]);
        repeat (len) push_word(16'($urandom));
        push_rep(8'hAA, 8);
    endtask

    // Next byte of the stream; a stall of GAP idle clocks while mid-frame becomes a timeout.
    task automatic fetch(input bit active, output int st, output logic [7:0] b);
        b = 8'h00;
        for (int k = cur + 1; k < s_vld.size(); k++) begin
            if (s_rst[k]) begin cur = k; st = ST_RST; return; end
            if (s_vld[k]) begin cur = k; b = s_dat[k]; st = ST_BYTE; return; end
            if (active && (k - cur == GAP)) begin
                cur = k; e_fe[k] = 1'b1; e_code[k] = 2'd3; st = ST_TO; return;
            end
        end
        cur = s_vld.size();
        st  = ST_END;
    endtask

    task automatic model_frame(output bit stop);
        int st, hc, len;
        logic [7:0] b, lo;
        stop = 1'b0;
        hc = 0;
        while (hc < 12) begin
            fetch(hc > 0, st, b);
            if (st != ST_BYTE) begin stop = (st == ST_END); return; end
            hc = (b == 8'h55) ? hc + 1 : 0;
        end
        fetch(1'b1, st, lo);
        if (st != ST_BYTE) begin stop = (st == ST_END); return; end
        fetch(1'b1, st, b);
        if (st != ST_BYTE) begin stop = (st == ST_END); return; end
        len = int'({b, lo});
        if (len > MAXW) begin e_fe[cur] = 1'b1; e_code[cur] = 2'd1; return; end
        for (int w = 0; w < len; w++) begin
            fetch(1'b1, st, lo);
            if (st != ST_BYTE) begin stop = (st == ST_END); return; end
            fetch(1'b1, st, b);
            if (st != ST_BYTE) begin stop = (st == ST_END); return; end
            e_wv[cur] = 1'b1; e_wd[cur] = {b, lo}; e_wa[cur] = 8'(w);
        end
        for (int t = 0; t < 8; t++) begin
            fetch(1'b1, st, b);
            if (st != ST_BYTE) begin stop = (st == ST_END); return; end
            if (b != 8'hAA) begin e_fe[cur] = 1'b1; e_code[cur] = 2'd2; return; end
        end
        e_fd[cur] = 1'b1;
    endtask

    task automatic build_model();
        int n;
        bit stop;
        logic [1:0] ec;
        n = s_vld.size();
        e_wv = new[n]; e_fd = new[n]; e_fe = new[n];
        e_wd = new[n]; e_wa = new[n]; e_code = new[n];
        for (int k = 0; k < n; k++) begin
            e_wv[k] = 0; e_fd[k] = 0; e_fe[k] = 0; e_wd[k] = 0; e_wa[k] = 0; e_code[k] = 0;
        end
        cur = -1;
        stop = 1'b0;
        while (!stop) model_frame(stop);
        ec = 2'd0;
        expv.delete();
        for (int k = 0; k < n; k++) begin
            if (s_rst[k]) ec = 2'd0;
            if (e_fe[k]) ec = e_code[k];
            expv.push_back({e_wv[k], e_fd[k], e_fe[k], ec,
                            e_wv[k] ? e_wd[k] : 16'h0, e_wv[k] ? e_wa[k] : 8'h0});
        end
    endtask

    task automatic play();
        obs.delete();
        raw.delete();
        for (int k = 0; k < s_vld.size(); k++) begin
            @(negedge clk);
            rst = s_rst[k]; byte_valid = s_vld[k]; byte_data = s_dat[k];
            @(posedge clk);
            #1;
            obs.push_back({word_valid, frame_done, frame_error, err_code,
                           word_valid ? word_data : 16'h0, word_valid ? word_addr : 8'h0});
            raw.push_back({word_data, word_addr});
        end
        @(negedge clk);
        rst = 1'b0; byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; byte_valid = 1'b1; byte_data = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (word_valid !== 1'b0) $display("FAIL reset_word_valid got %b want 0", word_valid); else passed++;
        checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", frame_done); else passed++;
        checks++; if (frame_error !== 1'b0) $display("FAIL reset_frame_error got %b want 0", frame_error); else passed++;
        checks++; if (err_code !== 2'd0) $display("FAIL reset_err_code got %0d want 0", err_code); else passed++;
        checks++; if (word_data !== 16'h0) $display("FAIL reset_word_data got %h want 0", word_data); else passed++;
        checks++; if (word_addr !== 8'h0) $display("FAIL reset_word_addr got %h want 0", word_addr); else passed++;
        @(negedge clk);
        rst = 1'b0; byte_valid = 1'b0;
    endtask

    task automatic test_basic();
        logic [23:0] got[$];
        logic [23:0] g0, g1;
        int last;
        jitter = 0;
        clear_stim();
        push_rep(8'h55, 12);
        push_word(16'h0002); push_word(16'h1234); push_word(16'hABCD);
        push_rep(8'hAA, 8);
        last = s_vld.size() - 1;
        push_idle(3);
        build_model();
        play();
        for (int k = 0; k < obs.size(); k++) begin
            checks++;
            if (obs[k] !== expv[k]) $display("FAIL basic cyc %0d got %h want %h", k, obs[k], expv[k]);
            else passed++;
            if (obs[k][28]) got.push_back(obs[k][23:0]);
        end
        g0 = (got.size() > 0) ? got[0] : 24'hxxxxxx;
        g1 = (got.size() > 1) ? got[1] : 24'hxxxxxx;
        checks++; if (got.size() != 2) $display("FAIL basic_word_count got %0d want 2", got.size()); else passed++;
        checks++; if (g0 !== 24'h123400) $display("FAIL basic_word0 got %h want 123400", g0); else passed++;
        checks++; if (g1 !== 24'hABCD01) $display("FAIL basic_word1 got %h want abcd01", g1); else passed++;
        checks++; if (obs[last][27] !== 1'b1) $display("FAIL basic_frame_done got %b want 1", obs[last][27]); else passed++;
    endtask

    task automatic test_partial_header();
        jitter = 0;
        clear_stim();
        push_rep(8'h55, 11); push_byte(8'h00);
        push_frame(1);
        push_idle(3);
        build_model();
        play();
        for (int k = 0; k < obs.size(); k++) begin
            checks++;
            if (obs[k] !== expv[k]) $display("FAIL partial_hdr cyc %0d got %h want %h", k, obs[k], expv[k]);
            else passed++;
        end
    endtask

    task automatic test_len_overflow();
        int msb;
        jitter = 0;
        clear_stim();
        push_rep(8'h55, 12); push_byte(8'h01);
        msb = s_vld.size();
        push_byte(8'h01);
        push_idle(2);
        push_frame(MAXW);
        push_idle(2);
        build_model();
        play();
        for (int k = 0; k < obs.size(); k++) begin
            checks++;
            if (obs[k] !== expv[k]) $display("FAIL len_overflow cyc %0d got %h want %h", k, obs[k], expv[k]);
            else passed++;
        end
        checks++;
        if (obs[msb][28:24] !== 5'b00101) $display("FAIL len_overflow_err got %b want 00101", obs[msb][28:24]);
        else passed++;
    endtask

    task automatic test_bad_trailer();
        int bad;
        jitter = 0;
        clear_stim();
        push_rep(8'h55, 12); push_word(16'h0001); push_word(16'hBEEF);
        push_rep(8'hAA, 7);
        bad = s_vld.size();
        push_byte(8'h55);
        push_frame(2);
        push_idle(2);
        build_model();
        play();
        for (int k = 0; k < obs.size(); k++) begin
            checks++;
            if (obs[k] !== expv[k]) $display("FAIL bad_trailer cyc %0d got %h want %h", k, obs[k], expv[k]);
            else passed++;
        end
        checks++;
        if (obs[bad][28:24] !== 5'b00110) $display("FAIL bad_trailer_err got %b want 00110", obs[bad][28:24]);
        else passed++;
    endtask

    task automatic test_gap_timeout();
        int to_idx, done_idx;
        jitter = 0;
        clear_stim();
        push_rep(8'h55, 12); push_word(16'h0000);
        to_idx = s_vld.size() - 1 + GAP;
        push_idle(GAP + 3);
        push_rep(8'h55, 12); push_word(16'h0000);
        push_idle(GAP - 1);
        push_rep(8'hAA, 8);
        done_idx = s_vld.size() - 1;
        push_idle(2);
        build_model();
        play();
        for (int k = 0; k < obs.size(); k++) begin
            checks++;
            if (obs[k] !== expv[k]) $display("FAIL gap_timeout cyc %0d got %h want %h", k, obs[k], expv[k]);
            else passed++;
        end
        checks++;
        if (obs[to_idx][28:24] !== 5'b00111) $display("FAIL gap_timeout_err got %b want 00111", obs[to_idx][28:24]);
        else passed++;
        checks++;
        if (obs[done_idx][27] !== 1'b1) $display("FAIL gap_terminal_byte got %b want 1", obs[done_idx][27]);
        else passed++;
    endtask

    task automatic test_reset_midframe();
        int r_idx;
        jitter = 0;
        clear_stim();
        push_rep(8'h55, 12); push_word(16'h0003); push_word(16'h1234); push_byte(8'h77);
        r_idx = s_vld.size();
        push_rst();
        push_idle(2);
        push_frame(3);
        push_idle(2);
        build_model();
        play();
        for (int k = 0; k < obs.size(); k++) begin
            checks++;
            if (obs[k] !== expv[k]) $display("FAIL reset_midframe cyc %0d got %h want %h", k, obs[k], expv[k]);
            else passed++;
        end
        checks++;
        if (raw[r_idx] !== 24'h0) $display("FAIL reset_midframe_data got %h want 000000", raw[r_idx]);
        else passed++;
    endtask

    task automatic test_random();
        int r, j;
        logic [7:0] nb;
        jitter = 1;
        clear_stim();
        for (int f = 0; f < 14; f++) begin
            r = $urandom_range(0, 6);
            case (r)
                0: push_frame($urandom_range(0, 6));
                1: begin
                    push_rep(8'h55, 12);
                    push_word(16'($urandom_range(MAXW + 1, 16'hFFFF)));
                end
                2: begin
                    push_rep(8'h55, 12); push_word(16'h0001); push_word(16'($urandom));
                    j = $urandom_range(0, 7);
                    push_rep(8'hAA, j);
                    nb = 8'($urandom);
                    if (nb == 8'hAA) nb = 8'h00;
                    push_byte(nb);
                end
                3: repeat ($urandom_range(1, 6)) push_byte(8'($urandom));
                4: begin
                    push_rep(8'h55, $urandom_range(1, 11));
                    push_byte(8'($urandom_range(0, 8'h54)));
                end
                5: begin
                    push_rep(8'h55, 12); push_byte(8'($urandom));
                    push_idle(GAP + $urandom_range(0, 3));
                end
                default: push_frame((f == 6) ? MAXW : $urandom_range(1, 4));
            endcase
        end
        push_idle(3);
        build_model();
        play();
        for (int k = 0; k < obs.size(); k++) begin
            checks++;
            if (obs[k] !== expv[k]) $display("FAIL random cyc %0d got %h want %h", k, obs[k], expv[k]);
            else passed++;
        end
        jitter = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial_header();
        test_len_overflow();
        test_bad_trailer();
        test_gap_timeout();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
